// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for alu_mc: issue side (in_*) and writeback side (out_*).
interface alu_mc_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle RV32I-style ALU: single-cycle logic ops, iterative shifts, optional shift-add MUL.
// Define ALU_MC_MUL_EN to build the multiplier; otherwise op 1010 is reported illegal.
module alu_mc #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);
    localparam int SHW = $clog2(XLEN);
    localparam int SW  = SHW + 1;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
`ifdef ALU_MC_MUL_EN
        , S_MUL
`endif
    } state_t;

    state_t          state, state_nxt;
    logic [3:0]      op_q;
    logic [XLEN-1:0] acc;
    logic [SW-1:0]   rem;
    logic [SW-1:0]   amt;
    logic [XLEN-1:0] shift_nxt;
    logic [XLEN-1:0] result_q;
    logic            zero_q;
    logic            illegal_q;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] fast_res;
    logic            is_shift;
    logic            is_mul;
    logic            op_ill;

`ifdef ALU_MC_MUL_EN
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] prod;
    logic [XLEN-1:0] prod_nxt;
    logic [SHW-1:0]  cnt;

    assign prod_nxt = prod + (mplier[0] ? mcand : '0);
`endif

    assign shamt         = bus.b[SHW-1:0];
    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.illegal   = illegal_q;

    // Capture-cycle result; shifts with shamt==0 also complete here with a unchanged.
    always_comb begin
        fast_res = '0;
        is_shift = 1'b0;
        is_mul   = 1'b0;
        op_ill   = 1'b0;
        case (bus.op)
            OP_ADD:  fast_res = bus.a + bus.b;
            OP_SUB:  fast_res = bus.a - bus.b;
            OP_AND:  fast_res = bus.a & bus.b;
            OP_OR:   fast_res = bus.a | bus.b;
            OP_XOR:  fast_res = bus.a ^ bus.b;
            OP_SLT:  fast_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLTU: fast_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
            OP_SLL, OP_SRL, OP_SRA: begin
                fast_res = bus.a;
                is_shift = 1'b1;
            end
`ifdef ALU_MC_MUL_EN
            OP_MUL:  is_mul = 1'b1;
`endif
            default: op_ill = 1'b1;
        endcase
    end

    assign amt = (rem < SW'(SHIFT_STEP)) ? rem : SW'(SHIFT_STEP);

    always_comb begin
        case (op_q)
            OP_SLL:  shift_nxt = acc << amt;
            OP_SRA:  shift_nxt = $signed(acc) >>> amt;
            default: shift_nxt = acc >> amt;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (is_shift && shamt != '0)
                        state_nxt = S_SHIFT;
`ifdef ALU_MC_MUL_EN
                    else if (is_mul)
                        state_nxt = S_MUL;
`endif
                    else
                        state_nxt = S_DONE;
                end
            end
            S_SHIFT: if (rem == amt) state_nxt = S_DONE;
`ifdef ALU_MC_MUL_EN
            S_MUL:   if (cnt == '0) state_nxt = S_DONE;
`endif
            S_DONE:  if (bus.out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= '0;
            acc       <= '0;
            rem       <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef ALU_MC_MUL_EN
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            cnt       <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_q      <= bus.op;
                        acc       <= bus.a;
                        rem       <= SW'(shamt);
                        result_q  <= fast_res;
                        zero_q    <= (fast_res == '0);
                        illegal_q <= op_ill;
`ifdef ALU_MC_MUL_EN
                        mcand     <= bus.a;
                        mplier    <= bus.b;
                        prod      <= '0;
                        cnt       <= SHW'(XLEN - 1);
`endif
                    end
                end
                S_SHIFT: begin
                    acc <= shift_nxt;
                    rem <= rem - amt;
                    if (rem == amt) begin
                        result_q <= shift_nxt;
                        zero_q   <= (shift_nxt == '0);
                    end
                end
`ifdef ALU_MC_MUL_EN
                // One multiplier bit per cycle, LSB first; product is the low XLEN bits only.
                S_MUL: begin
                    prod   <= prod_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        result_q <= prod_nxt;
                        zero_q   <= (prod_nxt == '0);
                    end
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: driver queues expected results, negedge monitor checks them.
module tb_alu_mc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_mc_if #(.XLEN(32)) bus ();
    alu_mc_if #(.XLEN(32)) bus8 ();

    alu_mc #(.XLEN(32), .SHIFT_STEP(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    alu_mc #(.XLEN(32), .SHIFT_STEP(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare on the first cycle of each out_valid; verify hold while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (bus.out_valid && !prev_v) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got %h with no pending op", bus.result);
                end else begin
                    cur = q.pop_front();
                    chk("result", bus.result, cur.res);
                    chk("zero", 32'(bus.zero), 32'(cur.z));
                    chk("illegal", 32'(bus.illegal), 32'(cur.ill));
                    chk("latency_cycle", 32'(cyc), 32'(cur.cyc));
                end
            end else if (bus.out_valid && prev_v) begin
                chk("hold_result", bus.result, cur.res);
                chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            end
            prev_v = bus.out_valid;
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez, input logic ei,
                         input int lat, input bit track);
        int n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: in_ready=%0b required 1", bus.in_ready);
            return;
        end
        bus.op = op;
        bus.a = a;
        bus.b = b;
        bus.in_valid = 1'b1;
        if (track) begin
            e.res = er;
            e.z = ez;
            e.ill = ei;
            e.cyc = cyc + lat;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        bus.op = 4'($urandom_range(0, 15));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: pending=%0d required 0", q.size());
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n0;
        bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.op = '0; bus8.a = '0; bus8.b = '0; bus8.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_zero", 32'(bus.zero), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        rst_n = 1'b1;

        issue(4'b0000, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1, 1'b0, 1, 1'b1);
        issue(4'b0001, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1, 1'b1);
        issue(4'b0101, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b0, 1, 1'b1);
        issue(4'b0111, 32'h8000_0000, 32'd1, 32'd0, 1'b1, 1'b0, 1, 1'b1);
        issue(4'b0010, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1, 1'b1);
        issue(4'b0011, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1'b0, 1, 1'b1);
        issue(4'b0100, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 1'b0, 1'b0, 1, 1'b1);
        issue(4'b1001, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 32, 1'b1);
        issue(4'b1000, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 1'b0, 32, 1'b1);
        issue(4'b0110, 32'd1, 32'd0, 32'd1, 1'b0, 1'b0, 1, 1'b1);
        issue(4'b0110, 32'd3, 32'hFFFF_FFE4, 32'h0000_0030, 1'b0, 1'b0, 5, 1'b1);
        drain();

        bus.out_ready = 1'b0;
        issue(4'b0100, 32'h0000_1234, 32'h0000_1234, 32'd0, 1'b1, 1'b0, 1, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        drain();

`ifdef ALU_MC_MUL_EN
        issue(4'b1010, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0, 1'b0, 33, 1'b1);
`else
        issue(4'b1010, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b1, 1'b1, 1, 1'b1);
`endif
        issue(4'b1111, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1, 1, 1'b1);
        issue(4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1, 1'b1);
        drain();

        issue(4'b1001, 32'h8000_0000, 32'd31, 32'd0, 1'b0, 1'b0, 0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midshift_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midshift_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midshift_rst_result", bus.result, 32'd0);
        rst_n = 1'b1;
        issue(4'b0000, 32'd7, 32'd8, 32'd15, 1'b0, 1'b0, 1, 1'b1);
        drain();

        @(negedge clk);
        bus8.op = 4'b0110;
        bus8.a = 32'd1;
        bus8.b = 32'd31;
        bus8.in_valid = 1'b1;
        n0 = cyc;
        @(posedge clk);
        #1;
        bus8.in_valid = 1'b0;
        bus8.a = '0;
        bus8.b = '0;
        n = 0;
        @(negedge clk);
        while (!bus8.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("step8_latency", 32'(cyc - n0), 32'd5);
        chk("step8_result", bus8.result, 32'h8000_0000);

        drain();
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
